cpu: RTL and testbench
======================

Name: cpu

Overview:
- Five-stage in-order pipelined 32-bit MIPS-subset processor: IF, ID, EX, MEM, WB.
- Contains the PC, instruction memory, register file, control, hazard detection, forwarding, ALU and data memory.
- Top-level block of the core; memories and register file are preloaded hierarchically by the bench.

Parameters:
- IMEM_WORDS, 256, instruction memory depth in 32-bit words, indexed by PC[9:2].
- DMEM_BYTES, 32, data memory depth in bytes.

Ports:
- clk_i  input  1  single clock, rising-edge.
- rst_i  input  1  asynchronous active-low reset.
- start_i  input  1  run enable; PC advances only while high.

Behaviour:
- Reset (rst_i=0, async): PC=0; all pipeline registers cleared to NOP with all control bits 0.
- Register file, instruction memory and data memory are not reset; their contents are preloaded externally.
- Instruction set: add, sub, and, or (R-type, funct 0x20/0x22/0x24/0x25), addi (0x08), lw (0x23), sw (0x2B), beq (0x04), j (0x02). All-zero word is a NOP.
- Any other opcode/funct acts as NOP with no state change.
- PC update per cycle when start_i=1 and no stall: next = jump target, else branch target if taken, else PC+4. start_i=0 holds PC.
- Register file: 32x32, r0 always reads 0 and writes to r0 are ignored.
  - Writes occur in WB.
  - Same-cycle read of a register being written returns the new value (write-through bypass).
- Data memory: byte array, little-endian.
  - Word address is ALU result [4:0], word-aligned.
  - lw reads the 4 bytes combinationally; sw writes 4 bytes on the clock edge in MEM.
- Immediates are sign-extended.
- addi uses the signed 16-bit immediate; lw/sw address = rs + signext(imm).
- Arithmetic is 32-bit wraparound; no overflow traps.
- Branch/jump resolved in ID:
  - beq compares register-file outputs (with WB bypass only; no EX/MEM forwarding into ID).
  - Branch target = (PC+4 of beq) + (signext(imm)<<2).
  - Jump target = {PC+4[31:28], instr[25:0], 2'b00}.
  - On taken beq or j, IF/ID is flushed to NOP next cycle (one-cycle penalty).
- Load-use hazard:
  - Detected when ID/EX.MemRead=1, ID/EX.rt != 0, and ID/EX.rt equals IF/ID.rs or IF/ID.rt.
  - Response: hold PC and IF/ID; insert bubble (all control 0) into ID/EX for one cycle.
- Forwarding to EX ALU operands (rs and rt):
  - EX/MEM has priority over MEM/WB.
  - Applies only when the source has RegWrite=1 and dest != 0.
  - sw store data uses the forwarded rt value.
- Stall and flush in the same cycle: flush wins; PC takes the branch/jump target.
- Write-back destination: rd for R-type, rt for addi/lw. Write-back data: memory data for lw, ALU result otherwise.

Optional Feature:
- Macro MUL_EN.
  - Defined: R-type funct 0x18 (mul) writes the low 32 bits of rs*rt to rd, single-cycle in EX, forwardable like add.
  - Undefined: funct 0x18 decodes as NOP.

Test Plan:
- Reset then start_i=1 with all-NOP memory -> PC reads 0,4,8,... one step per cycle; all registers stay 0.
- addi r8,r0,5; add r9,r8,r8 back-to-back -> r9=10 via EX/MEM forwarding, no stall.
- Data mem[0]=5; lw r8,0(r0); add r9,r8,r8 -> exactly one stall cycle, PC held one cycle, r9=10.
- sw r9,4(r0) after r9=10 -> data word 0x04 reads 10, stored little-endian.
- beq r0,r0,+2 at PC=0 -> next fetch PC=12; instruction at PC=4 flushed, its destination unchanged; one flush counted.
- j 0x10 at PC=8 -> next PC=64; following instruction flushed. With MUL_EN, mul r10,r8,r8 with r8=5 -> r10=25.

Source files
------------

// File: rtl/cpu.sv
// cpu: five-stage in-order MIPS-subset core (IF, ID, EX, MEM, WB).
//
// Ports:
//   clk_i   - single rising-edge clock
//   rst_i   - asynchronous active-low reset; clears the PC and every pipeline
//             register to a NOP with all control bits low
//   start_i - run enable; while low the front end (PC and IF/ID) is frozen
//             and bubbles are fed into ID/EX so the back end drains
//
// Instruction memory (imem), register file (regs) and data memory (dmem) are
// never reset; their contents are preloaded hierarchically.
//
// Optional feature macro: MUL_EN. When defined, R-type funct 0x18 is a mul
// writing the low 32 bits of rs*rt to rd. When undefined, funct 0x18 is a NOP.
module cpu #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_BYTES = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i
);

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL} alu_op_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    alu_op_e     alu_op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
  } idex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        mem_to_reg;
    logic [4:0]  dst;
    logic [31:0] alu;
    logic [31:0] store_data;
  } exmem_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  dst;
    logic [31:0] alu;
    logic [31:0] mem_data;
  } memwb_t;

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] regs [32];
  logic [7:0]  dmem [DMEM_BYTES];

  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  idex_t       idex_q, idex_d;
  exmem_t      exmem_q, exmem_d;
  memwb_t      memwb_q, memwb_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // ---------------- ID ----------------
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_ext, rs_val, rt_val, wb_data, redirect_pc;
  logic        is_beq, is_j, flush, load_use;
  idex_t       dec;

  assign opcode  = ifid_q.instr[31:26];
  assign rs      = ifid_q.instr[25:21];
  assign rt      = ifid_q.instr[20:16];
  assign rd      = ifid_q.instr[15:11];
  assign funct   = ifid_q.instr[5:0];
  assign imm_ext = {{16{ifid_q.instr[15]}}, ifid_q.instr[15:0]};
  assign wb_data = memwb_q.mem_to_reg ? memwb_q.mem_data : memwb_q.alu;

  // Write-through: a value retiring in WB this cycle is visible to ID reads.
  always_comb begin
    rs_val = (rs == 5'd0) ? 32'd0 : regs[rs];
    rt_val = (rt == 5'd0) ? 32'd0 : regs[rt];
    if (memwb_q.reg_write && memwb_q.dst != 5'd0 && memwb_q.dst == rs) rs_val = wb_data;
    if (memwb_q.reg_write && memwb_q.dst != 5'd0 && memwb_q.dst == rt) rt_val = wb_data;
  end

  always_comb begin
    dec        = '0;
    dec.rs     = rs;
    dec.rt     = rt;
    dec.rs_val = rs_val;
    dec.rt_val = rt_val;
    dec.imm    = imm_ext;
    dec.alu_op = ALU_ADD;
    is_beq     = 1'b0;
    is_j       = 1'b0;
    case (opcode)
      6'h00: begin
        dec.dst       = rd;
        dec.reg_write = 1'b1;
        case (funct)
          6'h20:   dec.alu_op = ALU_ADD;
          6'h22:   dec.alu_op = ALU_SUB;
          6'h24:   dec.alu_op = ALU_AND;
          6'h25:   dec.alu_op = ALU_OR;
`ifdef MUL_EN
          6'h18:   dec.alu_op = ALU_MUL;
`endif
          default: dec.reg_write = 1'b0;  // includes the all-zero NOP
        endcase
      end
      6'h08: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.dst       = rt;
      end
      6'h23: begin
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec.alu_src   = 1'b1;
        dec.dst       = rt;
      end
      6'h2B: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      6'h04:   is_beq = 1'b1;
      6'h02:   is_j   = 1'b1;
      default: ;
    endcase
  end

  assign load_use = idex_q.mem_read && (idex_q.rt != 5'd0) &&
                    ((idex_q.rt == rs) || (idex_q.rt == rt));
  assign flush    = is_j || (is_beq && (rs_val == rt_val));
  assign redirect_pc = is_j ? {ifid_q.pc4[31:28], ifid_q.instr[25:0], 2'b00}
                            : ifid_q.pc4 + {imm_ext[29:0], 2'b00};

  // Front-end control. A redirect beats a load-use stall: the branch or jump
  // itself carries no control bits, so passing its decode is already a bubble.
  always_comb begin
    pc_d        = pc_q;
    ifid_d      = ifid_q;
    idex_d      = '0;
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (start_i) begin
      if (flush) begin
        pc_d        = redirect_pc;
        ifid_d      = '0;
        idex_d      = dec;
        flush_cnt_d = flush_cnt_q + 32'd1;
      end else if (load_use) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
        pc_d         = pc_q + 32'd4;
        ifid_d.instr = imem[pc_q[9:2]];
        ifid_d.pc4   = pc_q + 32'd4;
        idex_d       = dec;
      end
    end
  end

  // ---------------- EX ----------------
  logic [31:0] fwd_a, fwd_b, op_b, alu_res;

  always_comb begin
    fwd_a = idex_q.rs_val;
    fwd_b = idex_q.rt_val;
    if (memwb_q.reg_write && memwb_q.dst != 5'd0 && memwb_q.dst == idex_q.rs) fwd_a = wb_data;
    if (memwb_q.reg_write && memwb_q.dst != 5'd0 && memwb_q.dst == idex_q.rt) fwd_b = wb_data;
    // EX/MEM is the younger producer, so it overrides MEM/WB.
    if (exmem_q.reg_write && exmem_q.dst != 5'd0 && exmem_q.dst == idex_q.rs) fwd_a = exmem_q.alu;
    if (exmem_q.reg_write && exmem_q.dst != 5'd0 && exmem_q.dst == idex_q.rt) fwd_b = exmem_q.alu;
    op_b = idex_q.alu_src ? idex_q.imm : fwd_b;
    case (idex_q.alu_op)
      ALU_SUB: alu_res = fwd_a - op_b;
      ALU_AND: alu_res = fwd_a & op_b;
      ALU_OR:  alu_res = fwd_a | op_b;
`ifdef MUL_EN
      ALU_MUL: alu_res = fwd_a * op_b;
`endif
      default: alu_res = fwd_a + op_b;
    endcase
  end

  always_comb begin
    exmem_d            = '0;
    exmem_d.reg_write  = idex_q.reg_write;
    exmem_d.mem_write  = idex_q.mem_write;
    exmem_d.mem_to_reg = idex_q.mem_read;
    exmem_d.dst        = idex_q.dst;
    exmem_d.alu        = alu_res;
    exmem_d.store_data = fwd_b;
  end

  // ---------------- MEM ----------------
  logic [2:0]  word_idx;
  logic [31:0] mem_rdata;

  assign word_idx  = exmem_q.alu[4:2];
  assign mem_rdata = {dmem[{word_idx, 2'd3}], dmem[{word_idx, 2'd2}],
                      dmem[{word_idx, 2'd1}], dmem[{word_idx, 2'd0}]};

  always_comb begin
    memwb_d            = '0;
    memwb_d.reg_write  = exmem_q.reg_write;
    memwb_d.mem_to_reg = exmem_q.mem_to_reg;
    memwb_d.dst        = exmem_q.dst;
    memwb_d.alu        = exmem_q.alu;
    memwb_d.mem_data   = mem_rdata;
  end

  always_ff @(posedge clk_i) begin
    if (exmem_q.mem_write) begin
      dmem[{word_idx, 2'd0}] <= exmem_q.store_data[7:0];
      dmem[{word_idx, 2'd1}] <= exmem_q.store_data[15:8];
      dmem[{word_idx, 2'd2}] <= exmem_q.store_data[23:16];
      dmem[{word_idx, 2'd3}] <= exmem_q.store_data[31:24];
    end
  end

  // ---------------- WB ----------------
  always_ff @(posedge clk_i) begin
    if (memwb_q.reg_write && memwb_q.dst != 5'd0) regs[memwb_q.dst] <= wb_data;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q        <= '0;
      ifid_q      <= '0;
      idex_q      <= '0;
      exmem_q     <= '0;
      memwb_q     <= '0;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      ifid_q      <= ifid_d;
      idex_q      <= idex_d;
      exmem_q     <= exmem_d;
      memwb_q     <= memwb_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_cpu.sv
`timescale 1ns/1ps
module tb_cpu;
  logic clk_i   = 1'b0;
  logic rst_i   = 1'b0;
  logic start_i = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  logic [31:0] prog [$];

  cpu dut (.clk_i(clk_i), .rst_i(rst_i), .start_i(start_i));

  always #5 clk_i = ~clk_i;

  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25;
  localparam logic [5:0] F_MUL = 6'h18, F_BAD = 6'h26;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04;
`ifdef MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  function automatic logic [31:0] r_ins(input int s, input int t, input int d, input logic [5:0] fn);
    return {6'h00, 5'(s), 5'(t), 5'(d), 5'h00, fn};
  endfunction
  function automatic logic [31:0] i_ins(input logic [5:0] op, input int s, input int t, input logic [15:0] imm);
    return {op, 5'(s), 5'(t), imm};
  endfunction
  function automatic logic [31:0] j_ins(input logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction
  function automatic logic [31:0] sext(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_state();
    for (int i = 0; i < 32; i++) dut.regs[i] = 32'h0;
    for (int i = 0; i < 32; i++) dut.dmem[i] = 8'h0;
  endtask

  // Loads prog into instruction memory under reset, leaves start_i low.
  task automatic boot();
    start_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 256; i++) dut.imem[i] = (i < prog.size()) ? prog[i] : 32'h0;
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic step(input int n);
    start_i = 1'b1;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] dword(input int w);
    return {dut.dmem[4*w+3], dut.dmem[4*w+2], dut.dmem[4*w+1], dut.dmem[4*w]};
  endfunction

  // ---------------- table-driven single-program vectors ----------------
  typedef struct packed {
    logic [3:0][31:0] ins;
    logic [31:0]      r1v;
    logic [31:0]      r2v;
    logic [4:0]       chk;
    logic [31:0]      exp;
  } vec_t;
  vec_t tbl [$];

  function automatic vec_t mk(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] i2,
                              input logic [31:0] i3, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] e);
    vec_t v;
    v.ins[0] = i0; v.ins[1] = i1; v.ins[2] = i2; v.ins[3] = i3;
    v.r1v = a; v.r2v = b; v.chk = 5'd3; v.exp = e;
    return v;
  endfunction

  task automatic run_table();
    tbl.push_back(mk(r_ins(1,2,3,F_ADD), 0, 0, 0, 32'd7, 32'd5, 32'd12));
    tbl.push_back(mk(r_ins(1,2,3,F_SUB), 0, 0, 0, 32'd3, 32'd5, 32'hFFFF_FFFE));
    tbl.push_back(mk(r_ins(1,2,3,F_AND), 0, 0, 0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234));
    tbl.push_back(mk(r_ins(1,2,3,F_OR),  0, 0, 0, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F));
    tbl.push_back(mk(r_ins(1,2,3,F_ADD), 0, 0, 0, 32'hFFFF_FFFF, 32'd2, 32'd1));
    tbl.push_back(mk(i_ins(OP_ADDI,1,3,16'hFFFF), 0, 0, 0, 32'd0, 32'd0, 32'hFFFF_FFFF));
    tbl.push_back(mk(i_ins(OP_ADDI,1,3,16'h7FFF), 0, 0, 0, 32'h7FFF_FFFF, 32'd0, 32'h8000_7FFE));
    tbl.push_back(mk(i_ins(OP_ADDI,1,3,16'h8000), 0, 0, 0, 32'd0, 32'd0, 32'hFFFF_8000));
    tbl.push_back(mk(i_ins(OP_ADDI,1,0,16'd5), r_ins(0,0,3,F_ADD), 0, 0, 32'd9, 32'd0, 32'd0));
    tbl.push_back(mk(r_ins(1,2,3,F_BAD), 0, 0, 0, 32'd1, 32'd2, 32'hDEAD_BEEF));
    tbl.push_back(mk(i_ins(6'h0D,1,3,16'h00FF), 0, 0, 0, 32'd1, 32'd2, 32'hDEAD_BEEF));
    tbl.push_back(mk(i_ins(OP_ADDI,0,3,16'd4), 0, r_ins(3,3,3,F_ADD), 0, 32'd0, 32'd0, 32'd8));
    tbl.push_back(mk(i_ins(OP_ADDI,0,4,16'd6), 0, 0, r_ins(4,1,3,F_ADD), 32'd1, 32'd0, 32'd7));
    tbl.push_back(mk(i_ins(OP_ADDI,0,3,16'd1), i_ins(OP_ADDI,0,3,16'd2), r_ins(3,3,3,F_ADD), 0,
                     32'd0, 32'd0, 32'd4));
    tbl.push_back(mk(i_ins(OP_ADDI,0,2,16'd10), r_ins(1,2,3,F_SUB), 0, 0, 32'd3, 32'd0, 32'hFFFF_FFF9));
    tbl.push_back(mk(r_ins(1,2,3,F_MUL), 0, 0, 0, 32'd6, 32'd7, MUL_ON ? 32'd42 : 32'hDEAD_BEEF));
    foreach (tbl[i]) begin
      prog.delete();
      for (int k = 0; k < 4; k++) prog.push_back(tbl[i].ins[k]);
      clear_state();
      dut.regs[1] = tbl[i].r1v;
      dut.regs[2] = tbl[i].r2v;
      dut.regs[3] = 32'hDEAD_BEEF;
      boot();
      step(14);
      chk($sformatf("vec%0d", i), dut.regs[tbl[i].chk], tbl[i].exp);
    end
  endtask

  // ---------------- randomized programs vs. sequential ISA model ----------------
  task automatic rand_test(input int it);
    logic [31:0] mreg [8];
    logic [7:0]  mmem [32];
    logic [31:0] a, ins;
    logic [15:0] imm;
    int kind, s, t, d;
    mreg[0] = 32'h0;
    for (int r = 1; r < 8; r++) mreg[r] = $urandom;
    for (int b = 0; b < 32; b++) mmem[b] = 8'($urandom);
    clear_state();
    for (int r = 1; r < 8; r++) dut.regs[r] = mreg[r];
    for (int b = 0; b < 32; b++) dut.dmem[b] = mmem[b];
    prog.delete();
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 9));
      s    = int'($urandom_range(0, 7));
      t    = int'($urandom_range(0, 7));
      d    = int'($urandom_range(0, 7));
      imm  = 16'($urandom);
      a    = mreg[s] + sext(imm);
      case (kind)
        0: begin ins = r_ins(s,t,d,F_ADD); if (d != 0) mreg[d] = mreg[s] + mreg[t]; end
        1: begin ins = r_ins(s,t,d,F_SUB); if (d != 0) mreg[d] = mreg[s] - mreg[t]; end
        2: begin ins = r_ins(s,t,d,F_AND); if (d != 0) mreg[d] = mreg[s] & mreg[t]; end
        3: begin ins = r_ins(s,t,d,F_OR);  if (d != 0) mreg[d] = mreg[s] | mreg[t]; end
        4: begin ins = i_ins(OP_ADDI,s,t,imm); if (t != 0) mreg[t] = a; end
        5: begin
          ins = i_ins(OP_LW,s,t,imm);
          if (t != 0) mreg[t] = {mmem[{a[4:2],2'd3}], mmem[{a[4:2],2'd2}],
                                 mmem[{a[4:2],2'd1}], mmem[{a[4:2],2'd0}]};
        end
        6: begin
          ins = i_ins(OP_SW,s,t,imm);
          mmem[{a[4:2],2'd0}] = mreg[t][7:0];
          mmem[{a[4:2],2'd1}] = mreg[t][15:8];
          mmem[{a[4:2],2'd2}] = mreg[t][23:16];
          mmem[{a[4:2],2'd3}] = mreg[t][31:24];
        end
        7: ins = 32'h0;
        8: ins = r_ins(s,t,d,6'h27);
        default: begin
          ins = r_ins(s,t,d,F_MUL);
          if (MUL_ON && d != 0) mreg[d] = mreg[s] * mreg[t];
        end
      endcase
      prog.push_back(ins);
    end
    boot();
    step(130);
    for (int r = 1; r < 8; r++) chk($sformatf("rand%0d_r%0d", it, r), dut.regs[r], mreg[r]);
    for (int w = 0; w < 8; w++)
      chk($sformatf("rand%0d_m%0d", it, w), dword(w),
          {mmem[4*w+3], mmem[4*w+2], mmem[4*w+1], mmem[4*w]});
  endtask

  initial begin
    logic [31:0] acc;
    logic [31:0] pc_exp [4];

    // Asynchronous reset clears PC and the whole pipeline with no clock edge.
    clear_state();
    prog.delete();
    prog.push_back(i_ins(OP_ADDI,0,1,16'd1));
    prog.push_back(i_ins(OP_ADDI,0,2,16'd2));
    prog.push_back(i_ins(OP_ADDI,0,3,16'd3));
    boot();
    step(3);
    @(negedge clk_i);
    #1 rst_i = 1'b0;
    #2;
    chk("rst_pc", dut.pc_q, 32'h0);
    chk("rst_pipe", {31'd0, |{dut.ifid_q, dut.idex_q, dut.exmem_q, dut.memwb_q}}, 32'h0);

    // All-NOP memory: PC steps by 4 each cycle, registers untouched.
    clear_state();
    prog.delete();
    boot();
    for (int k = 1; k <= 6; k++) begin
      step(1);
      chk($sformatf("nop_pc%0d", k), dut.pc_q, 32'(4 * k));
    end
    step(6);
    acc = 32'h0;
    for (int i = 0; i < 32; i++) acc |= dut.regs[i];
    chk("nop_regs", acc, 32'h0);

    // Back-to-back dependent ALU ops: EX/MEM forwarding, no stall.
    clear_state();
    prog.delete();
    prog.push_back(i_ins(OP_ADDI,0,8,16'd5));
    prog.push_back(r_ins(8,8,9,F_ADD));
    boot();
    step(10);
    chk("fwd_r9", dut.regs[9], 32'd10);
    chk("fwd_stalls", dut.stall_cnt_q, 32'd0);

    // start_i low freezes the PC; resuming completes the program.
    boot();
    step(1);
    start_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("hold_pc", dut.pc_q, 32'd4);
    dut.regs[9] = 32'h0;
    step(10);
    chk("hold_r9", dut.regs[9], 32'd10);

    // Load-use: exactly one stall, PC held one cycle.
    clear_state();
    dut.dmem[0] = 8'd5;
    prog.delete();
    prog.push_back(i_ins(OP_LW,0,8,16'd0));
    prog.push_back(r_ins(8,8,9,F_ADD));
    boot();
    pc_exp[0] = 32'd4; pc_exp[1] = 32'd8; pc_exp[2] = 32'd8; pc_exp[3] = 32'd12;
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk($sformatf("lu_pc%0d", k), dut.pc_q, pc_exp[k]);
    end
    step(8);
    chk("lu_r9", dut.regs[9], 32'd10);
    chk("lu_stalls", dut.stall_cnt_q, 32'd1);

    // Store forwarded value, little-endian layout.
    clear_state();
    prog.delete();
    prog.push_back(i_ins(OP_ADDI,0,9,16'd10));
    prog.push_back(i_ins(OP_SW,0,9,16'd4));
    boot();
    step(10);
    chk("sw_word", dword(1), 32'd10);
    chk("sw_byte0", {24'd0, dut.dmem[4]}, 32'h0000_000A);

    // Taken beq at PC 0: skips PC 4 and 8, lands on 12.
    clear_state();
    dut.regs[5] = 32'h77;
    dut.regs[7] = 32'h88;
    prog.delete();
    prog.push_back(i_ins(OP_BEQ,0,0,16'd2));
    prog.push_back(i_ins(OP_ADDI,0,5,16'd99));
    prog.push_back(i_ins(OP_ADDI,0,7,16'd55));
    prog.push_back(i_ins(OP_ADDI,0,6,16'd1));
    boot();
    step(2);
    chk("beq_pc", dut.pc_q, 32'd12);
    step(10);
    chk("beq_r5", dut.regs[5], 32'h77);
    chk("beq_r7", dut.regs[7], 32'h88);
    chk("beq_r6", dut.regs[6], 32'd1);
    chk("beq_flush", dut.flush_cnt_q, 32'd1);

    // Jump at PC 8 to word 0x10 (byte 64); the following slot is flushed.
    clear_state();
    dut.regs[5] = 32'h77;
    prog.delete();
    prog.push_back(32'h0);
    prog.push_back(32'h0);
    prog.push_back(j_ins(26'h10));
    prog.push_back(i_ins(OP_ADDI,0,5,16'd99));
    for (int i = 4; i < 16; i++) prog.push_back(32'h0);
    prog.push_back(i_ins(OP_ADDI,0,6,16'd3));
    boot();
    step(4);
    chk("j_pc", dut.pc_q, 32'd64);
    step(10);
    chk("j_r5", dut.regs[5], 32'h77);
    chk("j_r6", dut.regs[6], 32'd3);
    chk("j_flush", dut.flush_cnt_q, 32'd1);

    // mul with forwarded operand (NOP when the feature is off).
    clear_state();
    dut.regs[10] = 32'h1234_5678;
    prog.delete();
    prog.push_back(i_ins(OP_ADDI,0,8,16'd5));
    prog.push_back(r_ins(8,8,10,F_MUL));
    boot();
    step(10);
    chk("mul_r10", dut.regs[10], MUL_ON ? 32'd25 : 32'h1234_5678);

    run_table();
    for (int it = 0; it < 3; it++) rand_test(it);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
